ahblite_busmatrix_decoder_param: RTL and testbench



---
 rtl/ahblite_busmatrix_decoder_param_if.sv | 28 ++
 rtl/ahblite_busmatrix_decoder_param.sv | 114 +++++++++++
 tb/tb_ahblite_busmatrix_decoder_param.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_busmatrix_decoder_param_if.sv
// AHB-Lite signals between one input stage, the decoder and its output stages.
// The decoder connects through the slave modport; the driving side uses master.
interface ahblite_busmatrix_decoder_param_if #(
  parameter int unsigned NUM_SLAVES = 2
);
  logic                     HREADY;
  logic [31:0]              HADDR;
  logic [1:0]               HTRANS;
  logic [NUM_SLAVES-1:0]    ACTIVE_I;
  logic [NUM_SLAVES-1:0]    HREADYOUT_I;
  logic [2*NUM_SLAVES-1:0]  HRESP_I;
  logic [32*NUM_SLAVES-1:0] HRDATA_I;
  logic [NUM_SLAVES-1:0]    HSEL_O;
  logic                     ACTIVE;
  logic                     HREADYOUT;
  logic [1:0]               HRESP;
  logic [31:0]              HRDATA;

  modport slave (
    input  HREADY, HADDR, HTRANS, ACTIVE_I, HREADYOUT_I, HRESP_I, HRDATA_I,
    output HSEL_O, ACTIVE, HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HREADY, HADDR, HTRANS, ACTIVE_I, HREADYOUT_I, HRESP_I, HRDATA_I,
    input  HSEL_O, ACTIVE, HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_busmatrix_decoder_param.sv
// AHB-Lite input-stage decoder: base/mask address decode to NUM_SLAVES output stages,
// registered data-phase response mux, and a default slave that errors and logs unmapped hits.
module ahblite_busmatrix_decoder_param #(
  parameter int unsigned                  NUM_SLAVES = 2,
  parameter logic [32*NUM_SLAVES-1:0]     ADDR_BASE  = {NUM_SLAVES{32'h0}},
  parameter logic [32*NUM_SLAVES-1:0]     ADDR_MASK  = {NUM_SLAVES{32'hFFFF0000}},
  parameter int unsigned                  ERR_CNT_W  = 8
) (
  input  logic                                 HCLK,
  input  logic                                 HRESETn,
  ahblite_busmatrix_decoder_param_if.slave     bus,
  input  logic                                 ERR_CLR,
  output logic [ERR_CNT_W-1:0]                 ERR_CNT,
  output logic [31:0]                          ERR_ADDR
);

  typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

  logic [NUM_SLAVES-1:0] hsel;
  logic                  active;
  logic                  unmapped;
  logic [NUM_SLAVES:0]   sel_d, sel_q;
  state_e                state_d, state_q;
  logic                  dflt_ready_d, dflt_ready_q;
  logic [1:0]            dflt_resp_d, dflt_resp_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d, err_cnt_q;
  logic [31:0]           err_addr_d, err_addr_q;
  logic                  unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];

  // Lowest index wins when windows overlap; ACTIVE defaults high when nothing hits.
  always_comb begin
    hsel   = '0;
    active = 1'b1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (((bus.HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) && (hsel == '0)) begin
        hsel[i] = 1'b1;
        active  = bus.ACTIVE_I[i];
      end
    end
  end

  assign bus.HSEL_O = hsel;
  assign bus.ACTIVE = active;

  assign unmapped = bus.HTRANS[1] & (hsel == '0) & bus.HREADY;

  // Top bit selects the default slave for the data phase.
  assign sel_d = bus.HREADY ? {unmapped, hsel} : sel_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (unmapped) state_d = StErr1;
      StErr1:  state_d = StErr2;
      StErr2:  state_d = unmapped ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase
    dflt_ready_d = (state_d != StErr1);
    dflt_resp_d  = (state_d == StIdle) ? 2'b00 : 2'b01;
  end

  // A clear coinciding with an unmapped transfer still logs that transfer.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (ERR_CLR) begin
      err_cnt_d  = '0;
      err_addr_d = '0;
    end
    if (unmapped) begin
      err_addr_d = bus.HADDR;
      if (err_cnt_d != '1) begin
        err_cnt_d = err_cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q        <= '0;
      state_q      <= StIdle;
      dflt_ready_q <= 1'b1;
      dflt_resp_q  <= 2'b00;
      err_cnt_q    <= '0;
      err_addr_q   <= '0;
    end else begin
      sel_q        <= sel_d;
      state_q      <= state_d;
      dflt_ready_q <= dflt_ready_d;
      dflt_resp_q  <= dflt_resp_d;
      err_cnt_q    <= err_cnt_d;
      err_addr_q   <= err_addr_d;
    end
  end

  always_comb begin
    bus.HREADYOUT = dflt_ready_q;
    bus.HRESP     = dflt_resp_q;
    bus.HRDATA    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        bus.HREADYOUT = bus.HREADYOUT_I[i];
        bus.HRESP     = bus.HRESP_I[2*i +: 2];
        bus.HRDATA    = bus.HRDATA_I[32*i +: 32];
      end
    end
  end

  assign ERR_CNT  = err_cnt_q;
  assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_ahblite_busmatrix_decoder_param.sv
// Randomised and directed bench for the AHB-Lite decoder against a transaction-level model;
// a second instance with a 2-bit error counter shares the stimulus.
module tb_ahblite_busmatrix_decoder_param;

  localparam logic [31:0] BASE [3] = '{32'h20000000, 32'h40010000, 32'h00000000};
  localparam logic [31:0] MASK [3] = '{32'hFFFFF000, 32'hFFFF0000, 32'hFFFF0000};

  logic HCLK;
  logic HRESETn;
  logic err_clr;
  logic [7:0]  err_cnt8;
  logic [1:0]  err_cnt2;
  logic [31:0] err_addr8, err_addr2;

  // Stimulus
  logic        hready;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  active_i, hreadyout_i;
  logic [5:0]  hresp_i;
  logic [95:0] hrdata_i;

  // Model state: m_tgt -1 none, 0..2 slave, 3 default slave; m_ecyc is the error cycle 1/2
  int m_tgt, m_ecyc, m_cnt8, m_cnt2;
  logic [31:0] m_eaddr;

  // Expected outputs for the current cycle
  logic [2:0]  exp_hsel;
  logic        exp_active, exp_ready;
  logic [1:0]  exp_resp;
  logic [31:0] exp_rdata;

  int n_checks, n_fail;

  ahblite_busmatrix_decoder_param_if #(.NUM_SLAVES(3)) bus ();
  ahblite_busmatrix_decoder_param_if #(.NUM_SLAVES(3)) bus2 ();

  assign bus2.HREADY      = bus.HREADY;
  assign bus2.HADDR       = bus.HADDR;
  assign bus2.HTRANS      = bus.HTRANS;
  assign bus2.ACTIVE_I    = bus.ACTIVE_I;
  assign bus2.HREADYOUT_I = bus.HREADYOUT_I;
  assign bus2.HRESP_I     = bus.HRESP_I;
  assign bus2.HRDATA_I    = bus.HRDATA_I;

  ahblite_busmatrix_decoder_param #(
    .NUM_SLAVES(3),
    .ADDR_BASE ({32'h00000000, 32'h40010000, 32'h20000000}),
    .ADDR_MASK ({32'hFFFF0000, 32'hFFFF0000, 32'hFFFFF000}),
    .ERR_CNT_W (8)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus),
    .ERR_CLR (err_clr),
    .ERR_CNT (err_cnt8),
    .ERR_ADDR(err_addr8)
  );

  ahblite_busmatrix_decoder_param #(
    .NUM_SLAVES(3),
    .ADDR_BASE ({32'h00000000, 32'h40010000, 32'h20000000}),
    .ADDR_MASK ({32'hFFFF0000, 32'hFFFF0000, 32'hFFFFF000}),
    .ERR_CNT_W (2)
  ) dut2 (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus2),
    .ERR_CLR (err_clr),
    .ERR_CNT (err_cnt2),
    .ERR_ADDR(err_addr2)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int win(input logic [31:0] a);
    for (int i = 0; i < 3; i++) begin
      if ((a & MASK[i]) == BASE[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_tgt = -1; m_ecyc = 0; m_cnt8 = 0; m_cnt2 = 0; m_eaddr = '0;
  endtask

  // Compute expectations from the model, drive HREADY as the bus would, settle.
  task automatic apply();
    int w;
    w = win(haddr);
    exp_hsel   = '0;
    exp_active = 1'b1;
    if (w >= 0) begin
      exp_hsel[w] = 1'b1;
      exp_active  = active_i[w];
    end
    if (m_tgt >= 0 && m_tgt < 3) begin
      exp_ready = hreadyout_i[m_tgt];
      exp_resp  = hresp_i[2*m_tgt +: 2];
      exp_rdata = hrdata_i[32*m_tgt +: 32];
    end else if (m_tgt == 3) begin
      exp_ready = (m_ecyc == 2);
      exp_resp  = 2'b01;
      exp_rdata = '0;
    end else begin
      exp_ready = 1'b1;
      exp_resp  = 2'b00;
      exp_rdata = '0;
    end
    hready = exp_ready;
    bus.HREADY = hready; bus.HADDR = haddr; bus.HTRANS = htrans;
    bus.ACTIVE_I = active_i; bus.HREADYOUT_I = hreadyout_i;
    bus.HRESP_I = hresp_i; bus.HRDATA_I = hrdata_i;
    #1;
  endtask

  task automatic tick();
    int w;
    logic unm;
    @(posedge HCLK);
    if (HRESETn) begin
      w   = win(haddr);
      unm = htrans[1] && (w < 0) && hready;
      if (err_clr) begin m_cnt8 = 0; m_cnt2 = 0; m_eaddr = '0; end
      if (unm) begin
        m_eaddr = haddr;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (hready) begin
        m_tgt  = unm ? 3 : w;
        m_ecyc = unm ? 1 : 0;
      end else if (m_tgt == 3 && m_ecyc == 1) begin
        m_ecyc = 2;
      end
    end
    @(negedge HCLK);
  endtask

  task automatic test_reset();
    apply();
    n_checks++; if (bus.HREADYOUT !== 1'b1) begin n_fail++;
      $display("FAIL reset_hreadyout: got %b expected 1", bus.HREADYOUT); end
    n_checks++; if (bus.HRESP !== 2'b00) begin n_fail++;
      $display("FAIL reset_hresp: got %b expected 00", bus.HRESP); end
    n_checks++; if (bus.HRDATA !== 32'h0) begin n_fail++;
      $display("FAIL reset_hrdata: got %h expected 0", bus.HRDATA); end
    n_checks++; if (err_cnt8 !== 8'h0 || err_cnt2 !== 2'h0) begin n_fail++;
      $display("FAIL reset_err_cnt: got %h/%h expected 0/0", err_cnt8, err_cnt2); end
    n_checks++; if (err_addr8 !== 32'h0) begin n_fail++;
      $display("FAIL reset_err_addr: got %h expected 0", err_addr8); end
    tick();
    HRESETn = 1'b1;
  endtask

  task automatic test_slave0();
    logic [31:0] d0;
    haddr = 32'h20000010; htrans = 2'b10; active_i = 3'b110; apply();
    n_checks++; if (bus.HSEL_O !== 3'b001) begin n_fail++;
      $display("FAIL s0_hsel: got %b expected 001", bus.HSEL_O); end
    n_checks++; if (bus.ACTIVE !== 1'b0) begin n_fail++;
      $display("FAIL s0_active: got %b expected 0", bus.ACTIVE); end
    tick();
    d0 = $urandom; hrdata_i = {$urandom, $urandom, d0}; htrans = 2'b00; haddr = 32'h20000FFC;
    apply();
    n_checks++; if (bus.HRDATA !== d0 || bus.HREADYOUT !== 1'b1) begin n_fail++;
      $display("FAIL s0_data: got %h/%b expected %h/1", bus.HRDATA, bus.HREADYOUT, d0); end
    htrans = 2'b10; tick();
    hreadyout_i = 3'b110; htrans = 2'b00; apply();
    n_checks++; if (bus.HREADYOUT !== 1'b0) begin n_fail++;
      $display("FAIL s0_wait: got %b expected 0", bus.HREADYOUT); end
    tick();
    hreadyout_i = 3'b111; apply();
    n_checks++; if (bus.HREADYOUT !== 1'b1) begin n_fail++;
      $display("FAIL s0_release: got %b expected 1", bus.HREADYOUT); end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] d1, d2;
    haddr = 32'h40010004; htrans = 2'b10; apply();
    n_checks++; if (bus.HSEL_O !== 3'b010) begin n_fail++;
      $display("FAIL s1_hsel: got %b expected 010", bus.HSEL_O); end
    tick();
    haddr = 32'h0; hreadyout_i = 3'b101;
    for (int k = 0; k < 3; k++) begin
      apply();
      n_checks++; if (bus.HREADYOUT !== 1'b0 || bus.HSEL_O !== 3'b100) begin n_fail++;
        $display("FAIL s1_stall%0d: got %b/%b expected 0/100", k, bus.HREADYOUT, bus.HSEL_O); end
      tick();
    end
    d1 = $urandom; d2 = $urandom; hrdata_i = {d2, d1, 32'hDEADBEEF}; hreadyout_i = 3'b111;
    apply();
    n_checks++; if (bus.HRDATA !== d1 || bus.HREADYOUT !== 1'b1) begin n_fail++;
      $display("FAIL s1_held: got %h/%b expected %h/1", bus.HRDATA, bus.HREADYOUT, d1); end
    tick();
    htrans = 2'b00; haddr = 32'h20000000; apply();
    n_checks++; if (bus.HRDATA !== d2) begin n_fail++;
      $display("FAIL s2_data: got %h expected %h", bus.HRDATA, d2); end
    tick();
  endtask

  task automatic test_unmapped();
    hrdata_i = {$urandom, $urandom, $urandom}; active_i = 3'b000;
    haddr = 32'h30000000; htrans = 2'b10; apply();
    n_checks++; if (bus.HSEL_O !== 3'b000 || bus.ACTIVE !== 1'b1) begin n_fail++;
      $display("FAIL um_decode: got %b/%b expected 000/1", bus.HSEL_O, bus.ACTIVE); end
    tick();
    htrans = 2'b00; haddr = 32'h20000000; apply();
    n_checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 2'b01 || bus.HRDATA !== 32'h0)
      begin n_fail++; $display("FAIL um_err1: got %b/%b/%h expected 0/01/0",
        bus.HREADYOUT, bus.HRESP, bus.HRDATA); end
    n_checks++; if (err_cnt8 !== 8'd1 || err_addr8 !== 32'h30000000) begin n_fail++;
      $display("FAIL um_log: got %0d/%h expected 1/30000000", err_cnt8, err_addr8); end
    tick();
    htrans = 2'b10; haddr = 32'h30000000; apply();
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b01) begin n_fail++;
      $display("FAIL um_err2: got %b/%b expected 1/01", bus.HREADYOUT, bus.HRESP); end
    tick();
    htrans = 2'b00; apply();
    n_checks++; if (bus.HREADYOUT !== 1'b0 || bus.HRESP !== 2'b01 || err_cnt8 !== 8'd2)
      begin n_fail++; $display("FAIL b2b_err1: got %b/%b/%0d expected 0/01/2",
        bus.HREADYOUT, bus.HRESP, err_cnt8); end
    tick();
    apply();
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b01) begin n_fail++;
      $display("FAIL b2b_err2: got %b/%b expected 1/01", bus.HREADYOUT, bus.HRESP); end
    tick();
    apply();
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b00 || err_cnt8 !== 8'd2)
      begin n_fail++; $display("FAIL idle_okay: got %b/%b/%0d expected 1/00/2",
        bus.HREADYOUT, bus.HRESP, err_cnt8); end
    tick();
  endtask

  task automatic test_saturate();
    err_clr = 1'b1; htrans = 2'b00; apply(); tick();
    err_clr = 1'b0; apply();
    n_checks++; if (err_cnt8 !== 8'd0 || err_cnt2 !== 2'd0 || err_addr8 !== 32'h0) begin
      n_fail++; $display("FAIL clr: got %0d/%0d/%h expected 0/0/0", err_cnt8, err_cnt2, err_addr8);
    end
    for (int k = 0; k < 5; k++) begin
      htrans = 2'b10; haddr = 32'h30000000 + 32'(k) * 32'h100; apply(); tick();
      htrans = 2'b00; apply(); tick();
    end
    htrans = 2'b10; haddr = 32'h30000500; err_clr = 1'b1; apply();
    n_checks++; if (err_cnt8 !== 8'd5 || err_cnt2 !== 2'd3 || err_addr8 !== 32'h30000400) begin
      n_fail++; $display("FAIL sat: got %0d/%0d/%h expected 5/3/30000400",
        err_cnt8, err_cnt2, err_addr8); end
    tick();
    err_clr = 1'b0; htrans = 2'b00; apply();
    n_checks++; if (err_cnt8 !== 8'd1 || err_cnt2 !== 2'd1 || err_addr2 !== 32'h30000500) begin
      n_fail++; $display("FAIL clr_hit: got %0d/%0d/%h expected 1/1/30000500",
        err_cnt8, err_cnt2, err_addr2); end
    tick(); apply(); tick();
  endtask

  task automatic test_reset_mid();
    htrans = 2'b10; haddr = 32'h30000000; apply(); tick();
    htrans = 2'b00; apply();
    HRESETn = 1'b0; model_reset(); #1;
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b00 || err_cnt8 !== 8'd0
        || err_addr8 !== 32'h0) begin n_fail++;
      $display("FAIL rst_mid: got %b/%b/%0d/%h expected 1/00/0/0",
        bus.HREADYOUT, bus.HRESP, err_cnt8, err_addr8); end
    tick();
    HRESETn = 1'b1;
    apply();
    n_checks++; if (bus.HREADYOUT !== 1'b1 || bus.HRESP !== 2'b00) begin n_fail++;
      $display("FAIL rst_idle: got %b/%b expected 1/00", bus.HREADYOUT, bus.HRESP); end
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0:       haddr = 32'h20000000 | ($urandom & 32'h00000FFF);
        1:       haddr = 32'h40010000 | ($urandom & 32'h0000FFFF);
        2:       haddr = $urandom & 32'h0000FFFF;
        default: haddr = $urandom;
      endcase
      htrans   = 2'($urandom_range(0, 3));
      active_i = 3'($urandom);
      for (int i = 0; i < 3; i++) hreadyout_i[i] = ($urandom_range(0, 3) != 0);
      hresp_i  = 6'($urandom) & 6'b010101;
      hrdata_i = {$urandom, $urandom, $urandom};
      err_clr  = ($urandom_range(0, 15) == 0);
      apply();
      n_checks++; if (bus.HSEL_O !== exp_hsel || bus.ACTIVE !== exp_active) begin n_fail++;
        $display("FAIL rnd_decode %0d: got %b/%b expected %b/%b", n, bus.HSEL_O, bus.ACTIVE,
          exp_hsel, exp_active); end
      n_checks++; if (bus.HREADYOUT !== exp_ready || bus.HRESP !== exp_resp) begin n_fail++;
        $display("FAIL rnd_resp %0d: got %b/%b expected %b/%b", n, bus.HREADYOUT, bus.HRESP,
          exp_ready, exp_resp); end
      n_checks++; if (bus.HRDATA !== exp_rdata) begin n_fail++;
        $display("FAIL rnd_rdata %0d: got %h expected %h", n, bus.HRDATA, exp_rdata); end
      n_checks++; if (err_cnt8 !== 8'(m_cnt8) || err_addr8 !== m_eaddr) begin n_fail++;
        $display("FAIL rnd_log %0d: got %0d/%h expected %0d/%h", n, err_cnt8, err_addr8,
          m_cnt8, m_eaddr); end
      n_checks++; if (err_cnt2 !== 2'(m_cnt2) || err_addr2 !== m_eaddr
          || bus2.HREADYOUT !== exp_ready) begin n_fail++;
        $display("FAIL rnd_w2 %0d: got %0d/%h/%b expected %0d/%h/%b", n, err_cnt2, err_addr2,
          bus2.HREADYOUT, m_cnt2, m_eaddr, exp_ready); end
      tick();
    end
    err_clr = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    HRESETn = 1'b1; err_clr = 1'b0;
    haddr = '0; htrans = 2'b00; active_i = 3'b111; hreadyout_i = 3'b111;
    hresp_i = '0; hrdata_i = '0; hready = 1'b1;
    model_reset();
    #2 HRESETn = 1'b0;
    @(negedge HCLK);
    test_reset();
    test_slave0();
    test_stall();
    test_unmapped();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
